// File: rtl/rsa_cmp_pkg.sv
// Shared types for the RSA comparator-sharing controllers: FSM states, index width helper, watchdog default.
// Pure declarations; no latency or backpressure of its own.
package rsa_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } cmp_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // Index width for n requesters, never narrower than one bit.
    function automatic int REQ_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request strictly after 'last', wrapping; one-hot grant plus index.
// Purely combinational, zero latency; no backpressure (the caller qualifies the grant).
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = int'(last) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = W'(c);
            end
        end
    end

endmodule

// File: rtl/cmp_share_ctrl.sv
// Time-shares one equality comparator among NUM_REQ requesters; grant-to-response is done latency + 2 cycles.
// Accepts one request per IDLE visit via combinational req_ready; ce low freezes everything and withholds ready.
module cmp_share_ctrl
    import rsa_cmp_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ce,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic                            rsp_equal,
    output logic                            rsp_timeout,
    output logic                            start_cmp,
    output logic [DATA_WIDTH-1:0]           in0,
    output logic [DATA_WIDTH-1:0]           in1,
    input  logic                            done_cmp,
    input  logic                            are_equal,
    output logic                            busy,
    output logic [REQ_IDX_W(NUM_REQ)-1:0]   grant_id
);

    localparam int IDX_W = REQ_IDX_W(NUM_REQ);
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Timer holds (k-1) during the k-th WAIT cycle, so this value marks the last allowed one.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    cmp_state_t             state;
    logic [IDX_W-1:0]       last;
    logic [TMR_W-1:0]       timer;
    logic [NUM_REQ-1:0]     gnt_q;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;
    logic [DATA_WIDTH-1:0]  sel_a;
    logic [DATA_WIDTH-1:0]  sel_b;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .last  (last),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        sel_a = req_a[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign req_ready = (ce && state == IDLE) ? arb_gnt : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= IDX_W'(NUM_REQ - 1);
            timer       <= '0;
            gnt_q       <= '0;
            grant_id    <= '0;
            in0         <= '0;
            in1         <= '0;
            start_cmp   <= 1'b0;
            rsp_valid   <= '0;
            rsp_equal   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        in0       <= sel_a;
                        in1       <= sel_b;
                        gnt_q     <= arb_gnt;
                        grant_id  <= arb_idx;
                        start_cmp <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_cmp <= 1'b0;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion coinciding with the watchdog expiry still reports the real result.
                    if (done_cmp) begin
                        rsp_equal   <= are_equal;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= gnt_q;
                        state       <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && timer == TMR_LAST) begin
                        rsp_equal   <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= gnt_q;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    last      <= grant_id;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Scoreboard bench for cmp_share_ctrl with a behavioural comparator of programmable latency (0 = hang).
module tb_cmp_share_ctrl;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int TMO = 16;

    logic           clk;
    logic           rst;
    logic           ce;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  rsp_valid;
    logic           rsp_equal;
    logic           rsp_timeout;
    logic           start_cmp;
    logic [DW-1:0]  in0;
    logic [DW-1:0]  in1;
    logic           done_cmp;
    logic           are_equal;
    logic           busy;
    logic [1:0]     grant_id;

    cmp_share_ctrl #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_equal   (rsp_equal),
        .rsp_timeout (rsp_timeout),
        .start_cmp   (start_cmp),
        .in0         (in0),
        .in1         (in1),
        .done_cmp    (done_cmp),
        .are_equal   (are_equal),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    typedef struct {
        logic [NR-1:0] vld;
        logic          eq;
        logic          to;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   lat_cfg = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Comparator model: counts enabled cycles after start, stalls with ce, forgets on reset.
    initial begin
        bit ce_s;
        bit armed;
        int k;
        int m_lat;
        armed = 0; k = 0; m_lat = 0;
        done_cmp  = 1'b0;
        are_equal = 1'b0;
        forever begin
            @(posedge clk);
            ce_s = ce;
            #1;
            if (rst) begin
                armed = 0;
            end else if (ce_s) begin
                if (armed) begin
                    if (done_cmp) armed = 0;
                    else k++;
                end
                if (start_cmp) begin
                    armed = 1;
                    k     = 0;
                    m_lat = lat_cfg;
                end
            end
            done_cmp  = armed && (m_lat != 0) && (k == m_lat);
            are_equal = done_cmp && (in0 == in1);
        end
    end

    // Monitor: every response strobe must match the oldest expectation, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid",   64'(rsp_valid),   64'(e.vld));
                    check("rsp_equal",   64'(rsp_equal),   64'(e.eq));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                    check("rsp_cycle",   64'(cyc),         64'(e.cyc));
                end
            end
        end
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the ISSUE cycle with t = handshake cycle.
    task automatic do_req(input int g, input logic [NR-1:0] vld, input int lat,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int stall, input bit push, input bit drop, output int t);
        logic [NR-1:0] exp_rdy;
        exp_t e;
        int n;
        bit to;
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        lat_cfg = lat;
        req_a[g*DW +: DW] = a;
        req_b[g*DW +: DW] = b;
        req_valid = vld;
        #1;
        n = 0;
        while (req_ready == '0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        t = cyc;
        if (push) begin
            to    = (lat == 0) || (lat > TMO);
            e.vld = exp_rdy;
            e.to  = to;
            e.eq  = !to && (a == b);
            e.cyc = t + (to ? TMO + 2 : lat + 2) + stall;
            sb.push_back(e);
        end
        @(negedge clk);
        check("start_cmp", 64'(start_cmp), 64'(1));
        check("in0",       64'(in0),       64'(a));
        check("in1",       64'(in1),       64'(b));
        check("grant_id",  64'(grant_id),  64'(g));
        check("ready_off", 64'(req_ready), 64'(0));
        if (drop) req_valid = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 64'(sb.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "global timeout");
    end

    initial begin
        int t;
        rst       = 1'b1;
        ce        = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset and idle: everything quiet, in0/in1 cleared.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  64'({req_ready, rsp_valid, rsp_equal, rsp_timeout, start_cmp, in0, in1, busy, grant_id}),
                  64'(0));
        end

        // Fairness from reset: all requesters valid, grants 0,1,2,3,0.
        req_a = {NR{8'h55}};
        req_b = {NR{8'h55}};
        for (int i = 0; i < 5; i++) begin
            do_req(i % NR, 4'hF, 3, 8'h55, 8'h55, 0, 1, (i == 4), t);
        end
        drain();

        // Single request, latency 8: response at T+10, not equal.
        do_req(2, 4'b0100, 8, 8'h55, 8'h15, 0, 1, 1, t);
        drain();

        // Watchdog: comparator hangs, response at T+18, busy falls at T+19.
        do_req(1, 4'b0010, 0, 8'h33, 8'h33, 0, 1, 1, t);
        wait_until(t + 18);
        check("busy_at_T18", 64'(busy), 64'(1));
        @(negedge clk);
        check("busy_at_T19", 64'(busy), 64'(0));
        drain();

        // Done on the 16th WAIT cycle beats the watchdog.
        do_req(3, 4'b1000, 16, 8'h3C, 8'h3C, 0, 1, 1, t);
        drain();

        // ce stall of 5 cycles inside WAIT delays the response by exactly 5.
        do_req(0, 4'b0001, 8, 8'hAA, 8'hAA, 5, 1, 1, t);
        wait_until(t + 3);
        req_valid = 4'b0010;
        ce = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_busy",  64'(busy),      64'(1));
            check("stall_ready", 64'(req_ready), 64'(0));
            check("stall_in0",   64'(in0),       64'(8'hAA));
        end
        req_valid = '0;
        ce = 1'b1;
        drain();

        // Reset mid-WAIT for requester 2: no response, pointer back to start.
        do_req(2, 4'b0100, 0, 8'h12, 8'h12, 0, 0, 1, t);
        wait_until(t + 4);
        check("busy_before_rst", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_rsp",   64'(rsp_valid), 64'(0));
        check("rst_in0",   64'(in0),       64'(0));
        rst = 1'b0;
        repeat (25) @(negedge clk);
        do_req(1, 4'b1010, 2, 8'h01, 8'h02, 0, 1, 0, t);
        do_req(3, 4'b1010, 2, 8'h07, 8'h07, 0, 1, 1, t);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_share_ctrl.md
Name: cmp_share_ctrl

Overview:
- Sequences and time-shares one bit_comp equality comparator among NUM_REQ requesters inside the RSA datapath, e.g. the exponent-loop FSM and the modular-reduction termination checks.
- Arbitrates round-robin and latches the winner's operands.
- Drives the comparator's start/operand pins, waits for done, then returns the result to the granted requester only.
- Includes a watchdog that releases the resource if the comparator hangs.

Parameters:
- DATA_WIDTH, 8, operand width; must match the bit_comp instance.
- NUM_REQ, 4, number of requesters; 2..16.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before forced completion; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when low all state holds.
- req_valid  in  NUM_REQ  per-requester request; held until ready.
- req_a  in  NUM_REQ*DATA_WIDTH  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*DATA_WIDTH  packed operand B.
- req_ready  out  NUM_REQ  one-hot accept, combinational.
- rsp_valid  out  NUM_REQ  one-hot result strobe, registered.
- rsp_equal  out  1  result; valid only with rsp_valid.
- rsp_timeout  out  1  watchdog fired; valid only with rsp_valid.
- start_cmp  out  1  comparator start pulse, registered.
- in0  out  DATA_WIDTH  comparator operand 0, registered copy of A.
- in1  out  DATA_WIDTH  comparator operand 1, registered copy of B.
- done_cmp  in  1  comparator completion.
- are_equal  in  1  comparator result; sampled with done_cmp.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.

Behaviour:
- Reset (async):
  - state=IDLE.
  - All outputs 0, including in0/in1.
  - Timer 0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- ce low:
  - No register updates.
  - req_ready forced to 0.
  - Registered outputs hold their value.
  - The comparator shares ce.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick g = the first set bit searching upward from last+1 (wrapping).
  - req_ready[g]=1 in this same cycle (T). valid&ready is the handshake.
  - Latch req_a[g] into in0 and req_b[g] into in1.
  - grant_id<=g. Next state ISSUE.
  - No request: stay in IDLE.
- ISSUE (cycle S=T+1):
  - start_cmp=1 for exactly this cycle.
  - in0/in1 stay stable from here until RESP completes.
  - Timer cleared. Next state WAIT.
- WAIT:
  - done_cmp=1: capture are_equal into rsp_equal, rsp_timeout=0, go to RESP.
  - Otherwise the timer increments.
  - If TIMEOUT_CYCLES!=0 and this is the TIMEOUT_CYCLES-th WAIT cycle: rsp_equal=0, rsp_timeout=1, go to RESP.
  - done_cmp and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[g]=1 for one cycle. last<=g. Next state IDLE.
  - Minimum grant-to-grant spacing is 4 cycles.
- Latency:
  - If done_cmp arrives L cycles after start (cycle S+L, L>=1), rsp_valid is at S+L+1 = T+L+2.
  - On timeout, rsp_valid is at S+TIMEOUT_CYCLES+1.
- done_cmp in IDLE, ISSUE or RESP is ignored.
- req_valid changes outside IDLE have no effect. A requester dropping valid before ready is legal (no grant is issued).
- Reset mid-operation: transaction abandoned, no rsp_valid, pointer reinitialised.
- Exactly one bit of req_ready and of rsp_valid may be high. Both are all-zero outside IDLE and RESP respectively.
- Timer width: $clog2(TIMEOUT_CYCLES+1). Saturation is not needed.

Decomposition:
- Shared package rsa_cmp_pkg holds:
  - the cmp_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - the REQ_IDX_W helper function;
  - the default TIMEOUT_CYCLES constant.
- Sub-module rr_arbiter: combinational rotate/priority/unrotate.
  - Inputs: req vector and last pointer.
  - Outputs: one-hot grant, index, any.
  - Reused by other shared-resource controllers.

Test Plan:
- Reset and idle: rst pulse, no requests -> all outputs 0, busy=0, in0=in1=0 for 10 cycles.
- Single request, comparator model latency 8:
  - Stimulus: req_valid=4'b0100, A=8'h55, B=8'h15.
  - req_ready=4'b0100 at T.
  - start_cmp at T+1 with in0=8'h55, in1=8'h15.
  - rsp_valid=4'b0100, rsp_equal=0 at T+10.
- Fairness: all four requesters continuously valid with A=B=8'h55 -> grant_id sequence 0,1,2,3,0. Each rsp_equal=1; no requester is granted twice before the others.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16, model never asserts done.
  - rsp_valid at T+18 with rsp_timeout=1, rsp_equal=0. busy drops at T+19.
  - Repeat with done at the 16th WAIT cycle -> rsp_timeout=0.
- Reset mid-WAIT:
  - rst during WAIT for requester 2 -> no rsp_valid, busy=0.
  - Then req_valid=4'b1010 -> requester 1 granted first.
- ce stall: ce=0 for 5 cycles inside WAIT (model also stalled) -> state and timer frozen, req_ready=0, rsp_valid delayed by exactly 5 cycles, result unchanged.
